// File: rtl/macro_sched.sv
// -----------------------------------------------------------------------------
// macro_sched
// Pass scheduler for a compute-in-memory macro. For every accepted 3x3 window
// it runs CHS_NUM passes. Each pass is EN_CYC cycles of macro_enable, then
// ADC_CYC cycles of macro_adc, then one capture cycle with ps_valid. Windows
// are counted, and frame_done marks the final capture of the last window of a
// FM_WIDTH x FM_WIDTH frame.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   mode_in        1 = compute, 0 = parameter load (blocks new windows)
//   verticle_sync  frame-start pulse; aborts any window in flight
//   win_valid      upstream presents a window
//   win_ready      window accepted this cycle (only combinational output)
//   macro_enable   macro compute enable
//   macro_adc      macro ADC convert strobe
//   chs_ps         partial-sum channel select (current pass)
//   ps_valid       macro output for pass chs_ps is ready to capture
//   frame_done     last capture of the last window in a frame
//   busy           scheduler not idle
//
// state | meaning
// IDLE  | waiting for a window
// EN    | macro_enable phase of the current pass
// ADC   | macro_adc phase of the current pass
// CAP   | one-cycle capture of the partial sum for the current pass
// -----------------------------------------------------------------------------
module macro_sched #(
  parameter int CHS_NUM  = 4,
  parameter int EN_CYC   = 2,
  parameter int ADC_CYC  = 1,
  parameter int FM_WIDTH = 56
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_in,
  input  logic       verticle_sync,
  input  logic       win_valid,
  output logic       win_ready,
  output logic       macro_enable,
  output logic       macro_adc,
  output logic [1:0] chs_ps,
  output logic       ps_valid,
  output logic       frame_done,
  output logic       busy
);

  localparam int WIN_TOTAL = FM_WIDTH * FM_WIDTH;
  localparam int WIN_W     = (WIN_TOTAL > 1) ? $clog2(WIN_TOTAL) : 1;

  localparam logic [1:0]       PASS_LAST = 2'(CHS_NUM - 1);
  localparam logic [3:0]       EN_LOAD   = 4'(EN_CYC - 1);
  localparam logic [3:0]       ADC_LOAD  = 4'(ADC_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EN   = 2'd1,
    ADC  = 2'd2,
    CAP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       pass, pass_nxt;
  logic [3:0]       phase, phase_nxt;
  logic [WIN_W-1:0] win_cnt, win_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pass    <= 2'd0;
      phase   <= 4'd0;
      win_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pass    <= pass_nxt;
      phase   <= phase_nxt;
      win_cnt <= win_cnt_nxt;
    end
  end

  assign win_ready = (state == IDLE) && mode_in && !verticle_sync;

  always_comb begin
    state_nxt   = state;
    pass_nxt    = pass;
    phase_nxt   = phase;
    win_cnt_nxt = win_cnt;
    if (verticle_sync) begin
      state_nxt   = IDLE;
      pass_nxt    = 2'd0;
      phase_nxt   = 4'd0;
      win_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid && win_ready) begin
            state_nxt = EN;
            pass_nxt  = 2'd0;
            phase_nxt = EN_LOAD;
          end
        end
        EN: begin
          if (phase == 4'd0) begin
            state_nxt = ADC;
            phase_nxt = ADC_LOAD;
          end else begin
            phase_nxt = phase - 4'd1;
          end
        end
        ADC: begin
          if (phase == 4'd0) begin
            state_nxt = CAP;
            phase_nxt = 4'd0;
          end else begin
            phase_nxt = phase - 4'd1;
          end
        end
        CAP: begin
          if (pass == PASS_LAST) begin
            state_nxt   = IDLE;
            pass_nxt    = 2'd0;
            win_cnt_nxt = (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
          end else begin
            state_nxt = EN;
            pass_nxt  = pass + 2'd1;
            phase_nxt = EN_LOAD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Strobes decode straight from flops, so they are glitch-free of inputs and
  // drop together with the state on reset or sync.
  assign macro_enable = (state == EN);
  assign macro_adc    = (state == ADC);
  assign ps_valid     = (state == CAP);
  assign chs_ps       = pass;
  assign busy         = (state != IDLE);
  assign frame_done   = (state == CAP) && (pass == PASS_LAST) && (win_cnt == WIN_LAST);

endmodule

// File: doc/macro_sched.md
MACRO_SCHED -- requirements
Module: macro_sched

Interface
REQ-001 Parameter CHS_NUM, default 4: number of partial-sum passes per window, selected through chs_ps; range 1..4.
REQ-002 Parameter EN_CYC, default 2: cycles macro_enable is held per pass; range 1..15.
REQ-003 Parameter ADC_CYC, default 1: cycles macro_adc is held per pass; range 1..15.
REQ-004 Parameter FM_WIDTH, default 56: windows per frame = FM_WIDTH*FM_WIDTH.
REQ-005 Port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port mode_in, input, 1 bit: 1 = compute, 0 = parameter-load (scheduler held idle).
REQ-008 Port verticle_sync, input, 1 bit: frame-start pulse.
REQ-009 Port win_valid, input, 1 bit: a sign-converted 3x3 window is presented to the macro.
REQ-010 Port win_ready, output, 1 bit: the scheduler accepts a window this cycle.
REQ-011 Port macro_enable, output, 1 bit: macro compute enable.
REQ-012 Port macro_adc, output, 1 bit: macro ADC convert strobe.
REQ-013 Port chs_ps, output, 2 bits: partial-sum channel select for the current pass.
REQ-014 Port ps_valid, output, 1 bit: the macro output for pass chs_ps is valid for capture by the partial-sum stage.
REQ-015 Port frame_done, output, 1 bit: one-cycle pulse after the last pass of the last window in a frame.
REQ-016 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, EN, ADC and CAP, with a pass counter (0..CHS_NUM-1), a phase counter and a window counter (0..FM_WIDTH*FM_WIDTH-1).
REQ-018 win_ready SHALL be 1 only in IDLE with mode_in=1 and verticle_sync=0.
REQ-019 A window SHALL be accepted when win_valid and win_ready are both 1; IDLE then goes to EN with pass=0.
REQ-020 In EN, macro_enable SHALL be 1 for exactly EN_CYC cycles, then the FSM goes to ADC.
REQ-021 In ADC, macro_adc SHALL be 1 for exactly ADC_CYC cycles, with macro_enable=0; the FSM then goes to CAP.
REQ-022 In CAP, ps_valid SHALL be 1 for one cycle; chs_ps SHALL equal the pass counter throughout EN, ADC and CAP.
REQ-023 From CAP, the FSM SHALL go to EN with pass+1 if pass<CHS_NUM-1; otherwise it SHALL go to IDLE and increment the window counter.
REQ-024 Timing: for acceptance at cycle t, with P = EN_CYC+ADC_CYC+1 (a full pass), pass k SHALL have macro_enable on cycles t+1+kP..t+EN_CYC+kP and ps_valid on cycle t+(k+1)P; win_ready SHALL return at t+CHS_NUM*P+1.
REQ-025 When the window counter reaches FM_WIDTH*FM_WIDTH-1 and that window's last CAP completes, frame_done SHALL pulse in the same cycle and the window counter SHALL wrap to 0.
REQ-026 verticle_sync=1 in any state SHALL force IDLE on the next edge, clear all counters and drop all strobes; a window in flight is abandoned with no further ps_valid and no frame_done.
REQ-027 mode_in=0 SHALL only block new acceptances; a window in flight SHALL complete normally.
REQ-028 win_valid while win_ready=0 SHALL NOT be accepted and SHALL NOT change state; upstream holds the window.
REQ-029 macro_enable, macro_adc and ps_valid SHALL be mutually exclusive in every cycle.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs except win_ready.

Reset
REQ-031 While rst=1: state=IDLE, all counters=0, and macro_enable, macro_adc, ps_valid, frame_done, busy=0, chs_ps=2'b00.
REQ-032 Assertion of rst SHALL take effect immediately regardless of clk; the first acceptance is possible on the first edge after rst deasserts.
REQ-033 Reset mid-window SHALL abandon the window with no residual strobes.

Verification
REQ-034 Defaults, mode_in=1, single win_valid at t=10: macro_enable at 11,12 / 15,16 / 19,20 / 23,24; macro_adc at 13/17/21/25; ps_valid at 14/18/22/26 with chs_ps=0,1,2,3; win_ready back at 27.
REQ-035 win_valid held high continuously: acceptances at cycles 10, 27 and 44 (17-cycle spacing); no overlap of passes.
REQ-036 FM_WIDTH=2, 4 back-to-back windows: frame_done pulses exactly once, coincident with the 16th ps_valid; the next window starts with chs_ps=0 and the window counter at 0.
REQ-037 verticle_sync at t=17 (pass 1, ADC phase): all strobes 0 from 18, IDLE, win_ready=1 at 18, no frame_done.
REQ-038 mode_in dropped at t=12 during a window: all 4 ps_valid still occur; win_ready stays 0 after completion until mode_in=1.
REQ-039 rst asserted at t=20 between clock edges: all outputs 0 immediately; after release, a fresh win_valid restarts at pass 0.
